// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// Opcodes, parser states and fixed ALU operand addresses.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_OP_A,
    S_OP_B,
    S_ALU_FUN
  } cmd_state_t;

endpackage

// File: rtl/frame_timeout_cnt.sv
// In-frame inactivity counter for the command parser.
// Flags expiry when the count reaches TIMEOUT_CYCLES-1 while running.
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // clear has priority; count only while a frame is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// Frame parser behind the UART receiver.
// Turns command frames into regfile/ALU strobes with error flags.
import uart_cmd_pkg::*;

module uart_rx_cmd_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  Parity_Error,
  input  logic                  Stop_Error,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  Cmd_Err,
  output logic                  Frame_Err,
  output logic                  Timeout_Err
);

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(CMD_WR);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(CMD_RD);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(CMD_ALU_OP);
  localparam logic [DATA_WIDTH-1:0] OP_NOP = DATA_WIDTH'(CMD_ALU_NOP);
  localparam logic [ADDR_WIDTH-1:0] A_ADDR = ADDR_WIDTH'(OPA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] B_ADDR = ADDR_WIDTH'(OPB_ADDR);

  cmd_state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [FUN_WIDTH-1:0]  fun_n;
  logic wr_n, rd_n, alu_n, cge_n;
  logic cmd_err_n, frame_err_n, to_err_n;
  logic bad_byte, good_byte, expired, to_fire;

  assign bad_byte  = RX_D_VLD && (Parity_Error || Stop_Error);
  assign good_byte = RX_D_VLD && !(Parity_Error || Stop_Error);
  assign to_fire   = expired && !RX_D_VLD;

  frame_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (CLK),
    .rst    (RST),
    .clr    (RX_D_VLD || to_fire),
    .run    (state != S_IDLE),
    .expired(expired)
  );

  // state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Cmd_Err     <= 1'b0;
      Frame_Err   <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_n;
      Address     <= addr_n;
      WrData      <= wdata_n;
      ALU_FUN     <= fun_n;
      WrEn        <= wr_n;
      RdEn        <= rd_n;
      ALU_EN      <= alu_n;
      CLK_GATE_EN <= cge_n;
      Cmd_Err     <= cmd_err_n;
      Frame_Err   <= frame_err_n;
      Timeout_Err <= to_err_n;
    end
  end

  // next state, latched fields and strobes
  always_comb begin
    state_n     = state;
    addr_n      = Address;
    wdata_n     = WrData;
    fun_n       = ALU_FUN;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    alu_n       = 1'b0;
    cmd_err_n   = 1'b0;
    frame_err_n = 1'b0;
    to_err_n    = 1'b0;
    if (bad_byte) begin
      frame_err_n = 1'b1;
      state_n     = S_IDLE;
    end else if (good_byte) begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            (RX_P_DATA == OP_WR):  state_n = S_WR_ADDR;
            (RX_P_DATA == OP_RD):  state_n = S_RD_ADDR;
            (RX_P_DATA == OP_ALU): state_n = S_OP_A;
            (RX_P_DATA == OP_NOP): state_n = S_ALU_FUN;
            default:               cmd_err_n = 1'b1;
          endcase
        end
        S_WR_ADDR: begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n = S_WR_DATA;
        end
        S_WR_DATA: begin
          wdata_n = RX_P_DATA;
          wr_n    = 1'b1;
          state_n = S_IDLE;
        end
        S_RD_ADDR: begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_n    = 1'b1;
          state_n = S_IDLE;
        end
        S_OP_A: begin
          addr_n  = A_ADDR;
          wdata_n = RX_P_DATA;
          wr_n    = 1'b1;
          state_n = S_OP_B;
        end
        S_OP_B: begin
          addr_n  = B_ADDR;
          wdata_n = RX_P_DATA;
          wr_n    = 1'b1;
          state_n = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          fun_n   = RX_P_DATA[FUN_WIDTH-1:0];
          alu_n   = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (to_fire) begin
      to_err_n = 1'b1;
      state_n  = S_IDLE;
    end
    // gate stays open for the whole ALU frame, through the start cycle
    cge_n = alu_n || (state_n == S_OP_A) ||
            (state_n == S_OP_B) || (state_n == S_ALU_FUN);
  end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser.
// Bytes driven on negedge, outputs checked on the following negedge.
module tb_uart_rx_cmd_parser;

  localparam int TC = 4096;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       Parity_Error;
  logic       Stop_Error;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] ALU_FUN;
  logic       ALU_EN;
  logic       CLK_GATE_EN;
  logic       Cmd_Err;
  logic       Frame_Err;
  logic       Timeout_Err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_rx_cmd_parser #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .FUN_WIDTH(4),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_P_DATA(RX_P_DATA),
    .RX_D_VLD(RX_D_VLD),
    .Parity_Error(Parity_Error),
    .Stop_Error(Stop_Error),
    .Address(Address),
    .WrData(WrData),
    .WrEn(WrEn),
    .RdEn(RdEn),
    .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN),
    .CLK_GATE_EN(CLK_GATE_EN),
    .Cmd_Err(Cmd_Err),
    .Frame_Err(Frame_Err),
    .Timeout_Err(Timeout_Err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {WrEn, RdEn, ALU_EN, Cmd_Err, Frame_Err, Timeout_Err}
  function automatic logic [31:0] strb();
    return {26'd0, WrEn, RdEn, ALU_EN, Cmd_Err, Frame_Err, Timeout_Err};
  endfunction

  task automatic send(input logic [7:0] b, input logic pe,
                      input logic se);
    @(negedge CLK);
    RX_P_DATA    = b;
    RX_D_VLD     = 1'b1;
    Parity_Error = pe;
    Stop_Error   = se;
    @(negedge CLK);
    RX_D_VLD     = 1'b0;
    Parity_Error = 1'b0;
    Stop_Error   = 1'b0;
  endtask

  initial begin
    RST          = 1'b1;
    RX_P_DATA    = 8'h00;
    RX_D_VLD     = 1'b0;
    Parity_Error = 1'b0;
    Stop_Error   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", {9'd0, Address, WrData, WrEn, RdEn, ALU_FUN,
        ALU_EN, CLK_GATE_EN, Cmd_Err, Frame_Err, Timeout_Err}, 32'd0);
    RST = 1'b0;

    // write frame
    send(8'hAA, 0, 0);
    chk("wr_after_op", strb(), 32'h00);
    send(8'h05, 0, 0);
    chk("wr_after_addr", strb(), 32'h00);
    send(8'h3C, 0, 0);
    chk("wr_strobe", strb(), 32'h20);
    chk("wr_addr", Address, 32'h5);
    chk("wr_data", WrData, 32'h3C);
    @(negedge CLK);
    chk("wr_one_cycle", strb(), 32'h00);

    // read frame, high nibble ignored
    send(8'hBB, 0, 0);
    send(8'hFA, 0, 0);
    chk("rd_strobe", strb(), 32'h10);
    chk("rd_addr", Address, 32'hA);

    // ALU with operands
    send(8'hCC, 0, 0);
    chk("alu_cge_rise", CLK_GATE_EN, 32'h1);
    send(8'h12, 0, 0);
    chk("opa_strobe", strb(), 32'h20);
    chk("opa_addr", Address, 32'h0);
    chk("opa_data", WrData, 32'h12);
    send(8'h34, 0, 0);
    chk("opb_strobe", strb(), 32'h20);
    chk("opb_addr", Address, 32'h1);
    chk("opb_data", WrData, 32'h34);
    chk("opb_cge", CLK_GATE_EN, 32'h1);
    send(8'h02, 0, 0);
    chk("alu_strobe", strb(), 32'h08);
    chk("alu_fun", ALU_FUN, 32'h2);
    chk("alu_cge_hold", CLK_GATE_EN, 32'h1);
    @(negedge CLK);
    chk("alu_cge_drop", {ALU_EN, CLK_GATE_EN}, 32'h0);

    // ALU without operands
    send(8'hDD, 0, 0);
    chk("nop_cge", CLK_GATE_EN, 32'h1);
    send(8'h07, 0, 0);
    chk("nop_strobe", strb(), 32'h08);
    chk("nop_fun", ALU_FUN, 32'h7);

    // unknown opcode
    send(8'h55, 0, 0);
    chk("cmd_err", strb(), 32'h04);
    @(negedge CLK);
    chk("cmd_err_pulse", Cmd_Err, 32'h0);

    // parity error mid-frame, then a clean read
    send(8'hAA, 0, 0);
    send(8'h05, 0, 0);
    send(8'h3C, 1, 0);
    chk("perr_strobe", strb(), 32'h02);
    chk("perr_wrdata_held", WrData, 32'h34);
    send(8'hBB, 0, 0);
    send(8'h03, 0, 0);
    chk("perr_recover_rd", strb(), 32'h10);
    chk("perr_recover_addr", Address, 32'h3);

    // stop error drops the ALU frame and gate
    send(8'hDD, 0, 0);
    send(8'h09, 0, 1);
    chk("serr_strobe", strb(), 32'h02);
    chk("serr_cge", CLK_GATE_EN, 32'h0);
    chk("serr_fun_held", ALU_FUN, 32'h7);

    // consecutive valid cycles are separate bytes
    @(negedge CLK);
    RX_D_VLD = 1'b1;
    RX_P_DATA = 8'hAA;
    @(negedge CLK);
    RX_P_DATA = 8'h06;
    @(negedge CLK);
    RX_P_DATA = 8'h77;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    chk("burst_strobe", strb(), 32'h20);
    chk("burst_addr", Address, 32'h6);
    chk("burst_data", WrData, 32'h77);

    // stall inside an ALU frame
    send(8'hCC, 0, 0);
    send(8'h12, 0, 0);
    repeat (TC - 1) @(negedge CLK);
    chk("tmo_not_yet", Timeout_Err, 32'h0);
    @(negedge CLK);
    chk("tmo_fire", strb(), 32'h01);
    chk("tmo_cge", CLK_GATE_EN, 32'h0);
    @(negedge CLK);
    chk("tmo_pulse", Timeout_Err, 32'h0);

    // byte on the expiry cycle wins
    send(8'hCC, 0, 0);
    send(8'h12, 0, 0);
    repeat (TC - 2) @(negedge CLK);
    send(8'h34, 0, 0);
    chk("edge_byte_strobe", strb(), 32'h20);
    chk("edge_byte_addr", Address, 32'h1);
    chk("edge_byte_data", WrData, 32'h34);
    send(8'h05, 0, 0);
    chk("edge_alu", strb(), 32'h08);
    chk("edge_alu_fun", ALU_FUN, 32'h5);

    // reset in the middle of a write frame
    send(8'hAA, 0, 0);
    RST = 1'b1;
    #1;
    chk("rst_mid_outs", {9'd0, Address, WrData, WrEn, RdEn, ALU_FUN,
        ALU_EN, CLK_GATE_EN, Cmd_Err, Frame_Err, Timeout_Err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    send(8'h05, 0, 0);
    chk("rst_then_cmd_err", strb(), 32'h04);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
